// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the core's data-memory port. A load or store is
// accepted with a req/ack handshake, held for WAIT_CYCLES wait states, and
// then answered with a one-cycle ack strobe. The answer carries registered
// load data (rdata) and an access-fault flag (err). Use it in place of a
// zero-latency store to run the datapath against slow memory.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words; valid byte addresses 0..4*DEPTH_WORDS-1
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous active-low reset
//   req    in   1   request, held by the initiator until ack
//   we     in   1   1 = store, 0 = load (sampled at acceptance)
//   addr   in   32  byte address (sampled at acceptance)
//   wdata  in   32  store data (sampled at acceptance)
//   be     in   4   byte enables, only with DMEM_BYTE_STROBE_EN defined
//   ack    out  1   one-cycle response strobe
//   rdata  out  32  load data, valid while ack=1, otherwise 0
//   err    out  1   misaligned or out-of-range access, valid while ack=1
//
// Configuration
//   DMEM_BYTE_STROBE_EN  when defined, adds port be. A store then writes
//                        only the bytes whose enable bit is set. Loads
//                        always return the full word.
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  be,
`endif
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  lat_be;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    // When WAIT_CYCLES is 0, the access completes on the same edge that
    // accepts it. The latches are not loaded yet at that point, so the
    // access fields come from the live inputs while in IDLE and from the
    // latched copies otherwise.
    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_fault;
    logic [IDX_W-1:0] acc_idx;
    logic             enter_resp;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
`ifdef DMEM_BYTE_STROBE_EN
        acc_be    = lat_be;
`else
        acc_be    = 4'hF;
`endif
        if (state == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
`ifdef DMEM_BYTE_STROBE_EN
            acc_be    = be;
`endif
        end
    end

    // The full 30-bit word index is compared, so a high address cannot
    // alias into the array.
    assign acc_fault = (acc_addr[1:0] != 2'b00) ||
                       (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_idx   = acc_addr[IDX_W+1:2];

    // This is the edge that enters RESP. It is gated by rst so that nothing
    // is written while reset is held, even if req is high in IDLE.
    always_comb begin
        enter_resp = 1'b0;
        if (rst) begin
            if (state == S_IDLE)
                enter_resp = req && (WAIT_CYCLES == 0);
            else if (state == S_WAIT)
                enter_resp = (wait_cnt <= 4'd1);
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i])
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
            lat_be    <= 4'd0;
`endif
            ack       <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
`ifdef DMEM_BYTE_STROBE_EN
                        lat_be    <= be;
`endif
                        wait_cnt  <= WAIT_INIT;
                        state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= 4'd0;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // The response outputs are registered on the edge entering
            // RESP. On every other edge they return to zero.
            if (enter_resp) begin
                ack   <= 1'b1;
                err   <= acc_fault;
                rdata <= (!acc_we && !acc_fault) ? mem[acc_idx] : 32'd0;
            end else begin
                ack   <= 1'b0;
                err   <= 1'b0;
                rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Scoreboard bench for data_mem_responder. It uses two instances:
//   dut   WAIT_CYCLES=2, DEPTH_WORDS=256
//   dut0  WAIT_CYCLES=0, DEPTH_WORDS=256
// When the driver sees a request accepted, it pushes the expected response
// into that instance's queue: rdata, err, and the cycle in which ack must be
// seen. A monitor samples on the falling edge, pops an entry on each ack and
// compares it.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int W2 = 2;
    localparam int W0 = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ack, err;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic        ack0, err0;
    logic [31:0] rdata0;

`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be  = 4'hF;
    logic [3:0]  be0 = 4'hF;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .be(be),
`endif
        .ack(ack), .rdata(rdata), .err(err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DMEM_BYTE_STROBE_EN
        .be(be0),
`endif
        .ack(ack0), .rdata(rdata0), .err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitors for both instances.
    always @(negedge clk) begin
        if (rst && ack) begin
            if (q.size() == 0) begin
                fail_event("dut: ack with empty scoreboard");
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, ".rdata"}, rdata, e.rdata);
                check({e.name, ".err"}, {31'd0, err}, {31'd0, e.err});
                check({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ack0) begin
            if (q0.size() == 0) begin
                fail_event("dut0: ack with empty scoreboard");
            end else begin
                exp_t e;
                e = q0.pop_front();
                check({e.name, ".rdata"}, rdata0, e.rdata);
                check({e.name, ".err"}, {31'd0, err0}, {31'd0, e.err});
                check({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Waits for the next ack of dut (falling-edge sampled), with a cycle bound.
    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        if (!seen) fail_event({name, ": ack timeout"});
    endtask

    // One access on dut. req is held until ack unless drop_early is set,
    // in which case it falls right after acceptance.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit drop_early, input string name);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        q.push_back('{exp_rd, exp_err, cyc + W2, name});
        if (drop_early) req = 1'b0;
        wait_ack(name);
        req = 1'b0;
    endtask

    task automatic access0(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input logic exp_err, input string name);
        bit seen = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        @(posedge clk);
        #1;
        q0.push_back('{exp_rd, exp_err, cyc + W0, name});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack0) seen = 1'b1;
        end
        if (!seen) fail_event({name, ": ack timeout"});
        req0 = 1'b0;
    endtask

    initial begin
        int a0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset.ack",   {31'd0, ack},  32'd0);
        check("reset.rdata", rdata,         32'd0);
        check("reset.err",   {31'd0, err},  32'd0);
        check("reset.ack0",  {31'd0, ack0}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic store/load and faults.
        access(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "store_10");
        access(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "load_10");
        access(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0, "load_misaligned_13");
        access(1'b1, 32'h00, 32'hA0A0A0A0, 32'h0, 1'b0, 1'b0, "store_0");
        access(1'b1, 32'h04, 32'hB1B1B1B1, 32'h0, 1'b0, 1'b0, "store_4");
        access(1'b1, 32'h08, 32'hC2C2C2C2, 32'h0, 1'b0, 1'b0, "store_8");
        access(1'b1, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "store_oob_400");
        access(1'b1, 32'h80000000, 32'hEEEEEEEE, 32'h0, 1'b1, 1'b0, "store_oob_high");
        access(1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, "store_last");
        access(1'b0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, "load_last");

        // Back-to-back loads with req held high: acks 4 cycles apart.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0;
        @(posedge clk);
        #1;
        a0 = cyc;
        q.push_back('{32'hA0A0A0A0, 1'b0, a0 + 2,  "b2b_load_0"});
        q.push_back('{32'hB1B1B1B1, 1'b0, a0 + 6,  "b2b_load_4"});
        q.push_back('{32'hC2C2C2C2, 1'b0, a0 + 10, "b2b_load_8"});
        addr = 32'h4;
        wait_ack("b2b_load_0");
        wait_ack("b2b_load_4");
        addr = 32'h8;
        wait_ack("b2b_load_8");
        req = 1'b0;

        // Reset in the middle of a store: no write, no ack.
        access(1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b0, "store_20_old");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h22222222;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_reset.ack", {31'd0, ack}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        access(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b0, "load_20_after_reset");

        // req dropped before ack still completes.
        access(1'b1, 32'h24, 32'h5A5A0F0F, 32'h0, 1'b0, 1'b1, "store_24_drop_early");
        access(1'b0, 32'h24, 32'h0, 32'h5A5A0F0F, 1'b0, 1'b1, "load_24_drop_early");

`ifdef DMEM_BYTE_STROBE_EN
        access(1'b1, 32'h30, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0, "be_store_full");
        be = 4'b0011;
        access(1'b1, 32'h30, 32'h00001122, 32'h0, 1'b0, 1'b0, "be_store_low");
        be = 4'b0000;
        access(1'b1, 32'h30, 32'h99999999, 32'h0, 1'b0, 1'b0, "be_store_none");
        be = 4'b0000;
        access(1'b0, 32'h30, 32'h0, 32'hAABB1122, 1'b0, 1'b0, "be_load");
        be = 4'hF;
`endif

        // Zero-wait instance: ack in the cycle right after acceptance.
        access0(1'b1, 32'h8, 32'h12345678, 32'h0, 1'b0, "w0_store_8");
        access0(1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, "w0_load_8");
        access0(1'b0, 32'h2, 32'h0, 32'h0, 1'b1, "w0_load_misaligned");

        // Drain the scoreboards.
        repeat (10) @(negedge clk);
        if (q.size() != 0)  fail_event("dut: expected responses never arrived");
        if (q0.size() != 0) fail_event("dut0: expected responses never arrived");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
